comp_seq: RTL and testbench

//   Sequencing stage directly upstream of the combinational comp equality block.

---
 rtl/comp_seq.sv | 131 +++++++++++++
 tb/tb_comp_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/comp_seq.sv
// comp_seq: handshake sequencer feeding the combinational comp equality block.
// Registers an operand pair onto comp's inputs, waits one settle cycle, samples
// the equality result and offers it downstream, while keeping saturating
// counts of comparisons completed and matches found.
module comp_seq #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic [WIDTH-1:0]     cmp_a_o,
   output logic [WIDTH-1:0]     cmp_b_o,
   input  logic                 cmp_equal_i,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic                 res_equal_o,
   input  logic                 clr_cnt_i,
   output logic [CNT_WIDTH-1:0] total_cnt_o,
   output logic [CNT_WIDTH-1:0] match_cnt_o
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]           state_q,     state_d;
   logic [WIDTH-1:0]     cmp_a_q,     cmp_a_d;
   logic [WIDTH-1:0]     cmp_b_q,     cmp_b_d;
   logic                 res_valid_q, res_valid_d;
   logic                 res_equal_q, res_equal_d;
   logic [CNT_WIDTH-1:0] total_q,     total_d;
   logic [CNT_WIDTH-1:0] match_q,     match_d;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      logic [CNT_WIDTH-1:0] one;
      one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      return (&v) ? v : v + one;
   endfunction

   // Only IDLE accepts a pair; reset masks ready so nothing is taken while held.
   assign in_ready_o  = (state_q == IDLE) && !rst_i;
   assign cmp_a_o     = cmp_a_q;
   assign cmp_b_o     = cmp_b_q;
   assign res_valid_o = res_valid_q;
   assign res_equal_o = res_equal_q;
   assign total_cnt_o = total_q;
   assign match_cnt_o = match_q;

   // Next-state for the FSM, operand registers and result path.
   always_comb begin
      state_d     = state_q;
      cmp_a_d     = cmp_a_q;
      cmp_b_d     = cmp_b_q;
      res_valid_d = res_valid_q;
      res_equal_d = res_equal_q;
      case (state_q)
         IDLE: begin
            if (in_valid_i && in_ready_o) begin
               cmp_a_d = a_i;
               cmp_b_d = b_i;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            // comp has had a full cycle to settle on the registered operands.
            res_equal_d = cmp_equal_i;
            res_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (res_ready_i) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // Next-state for the tallies; a clear wins over a coincident SETTLE count.
   always_comb begin
      total_d = total_q;
      match_d = match_q;
      if (clr_cnt_i) begin
         total_d = '0;
         match_d = '0;
      end else if (state_q == SETTLE) begin
         total_d = sat_inc(total_q);
         if (cmp_equal_i) begin
            match_d = sat_inc(match_q);
         end
      end
   end

   // FSM, operand and result registers; reset abandons any transaction.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cmp_a_q     <= '0;
         cmp_b_q     <= '0;
         res_valid_q <= 1'b0;
         res_equal_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmp_a_q     <= cmp_a_d;
         cmp_b_q     <= cmp_b_d;
         res_valid_q <= res_valid_d;
         res_equal_q <= res_equal_d;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         total_q <= '0;
         match_q <= '0;
      end else begin
         total_q <= total_d;
         match_q <= match_d;
      end
   end

endmodule

// File: tb/tb_comp_seq.sv
// tb_comp_seq: directed bench for comp_seq. Two instances share one stimulus
// stream (8-bit and 2-bit counters); each sees a behavioural comp on its
// registered operands.
module tb_comp_seq;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] a, b;
   logic       res_ready;
   logic       clr;

   logic       rdy8, rdy2;
   logic [7:0] ca8, cb8, ca2, cb2;
   logic       eq8, eq2;
   logic       rv8, rv2, re8, re2;
   logic [7:0] tot8, mat8;
   logic [1:0] tot2, mat2;

   int n_total = 0;
   int n_bad   = 0;

   assign eq8 = (ca8 == cb8);
   assign eq2 = (ca2 == cb2);

   comp_seq #(.WIDTH(8), .CNT_WIDTH(8)) dut8 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy8),
      .a_i(a), .b_i(b), .cmp_a_o(ca8), .cmp_b_o(cb8), .cmp_equal_i(eq8),
      .res_valid_o(rv8), .res_ready_i(res_ready), .res_equal_o(re8),
      .clr_cnt_i(clr), .total_cnt_o(tot8), .match_cnt_o(mat8)
   );

   comp_seq #(.WIDTH(8), .CNT_WIDTH(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy2),
      .a_i(a), .b_i(b), .cmp_a_o(ca2), .cmp_b_o(cb2), .cmp_equal_i(eq2),
      .res_valid_o(rv2), .res_ready_i(res_ready), .res_equal_o(re2),
      .clr_cnt_i(clr), .total_cnt_o(tot2), .match_cnt_o(mat2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with downstream always ready.
   task automatic run_pair(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic exp_eq);
      a = av; b = bv; in_valid = 1'b1; res_ready = 1'b1;
      step();                                  // accept edge
      in_valid = 1'b0;
      chk({tag, "_rv_e0"}, rv8, 0);
      chk({tag, "_ca"}, ca8, av);
      step();                                  // settle edge
      chk({tag, "_rv"}, rv8, 1);
      chk({tag, "_re"}, re8, exp_eq);
      step();                                  // result handshake
      chk({tag, "_rv_done"}, rv8, 0);
      chk({tag, "_rdy_back"}, rdy8, 1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; res_ready = 1'b0; clr = 1'b0;
      step(); step();
      chk("rst_rdy", rdy8, 0);
      chk("rst_rv", rv8, 0);
      chk("rst_tot", tot8, 0);
      chk("rst_ca", ca8, 0);
      rst = 1'b0;
      #1;
      chk("rst_rdy_rel", rdy8, 1);

      // 1: equal pair
      run_pair("t1", 8'hAA, 8'hAA, 1'b1);
      chk("t1_tot", tot8, 1);
      chk("t1_mat", mat8, 1);

      // 2: unequal pair
      run_pair("t2", 8'hF0, 8'h0F, 1'b0);
      chk("t2_tot", tot8, 2);
      chk("t2_mat", mat8, 1);

      // 3: downstream stall for 5 clocks, stray in_valid pulse dropped
      a = 8'h3C; b = 8'h3C; in_valid = 1'b1; res_ready = 1'b0;
      step();
      in_valid = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t3_rv", rv8, 1);
         chk("t3_re", re8, 1);
         chk("t3_ca", ca8, 8'h3C);
         chk("t3_cb", cb8, 8'h3C);
         chk("t3_rdy", rdy8, 0);
         if (i == 1) begin a = 8'h11; b = 8'h22; in_valid = 1'b1; end
         if (i == 2) in_valid = 1'b0;
         step();
      end
      res_ready = 1'b1;
      step();
      chk("t3_rv_done", rv8, 0);
      chk("t3_rdy_back", rdy8, 1);
      chk("t3_ca_kept", ca8, 8'h3C);
      chk("t3_tot", tot8, 3);
      chk("t3_mat", mat8, 2);

      // 4: clear, then 5 back-to-back equal pairs; 2-bit counters saturate
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t4_clr_tot", tot8, 0);
      chk("t4_clr_tot2", tot2, 0);
      for (int i = 0; i < 5; i++) begin
         run_pair("t4", 8'h00, 8'h00, 1'b1);
         chk("t4_tot2", tot2, (i + 1 > 3) ? 3 : i + 1);
         chk("t4_mat2", mat2, (i + 1 > 3) ? 3 : i + 1);
      end
      chk("t4_tot8", tot8, 5);
      chk("t4_mat8", mat8, 5);

      // 5: clear coincident with the SETTLE edge
      a = 8'h81; b = 8'h81; in_valid = 1'b1; res_ready = 1'b0;
      step();
      in_valid = 1'b0;
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t5_tot", tot8, 0);
      chk("t5_mat", mat8, 0);
      chk("t5_rv", rv8, 1);
      chk("t5_re", re8, 1);
      res_ready = 1'b1;
      step();
      chk("t5_rv_done", rv8, 0);
      chk("t5_tot_after", tot8, 0);

      // 6: reset during SETTLE
      a = 8'h55; b = 8'h55; in_valid = 1'b1; res_ready = 1'b1;
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      chk("t6_rv", rv8, 0);
      chk("t6_re", re8, 0);
      chk("t6_ca", ca8, 0);
      chk("t6_rdy", rdy8, 0);
      rst = 1'b0;
      #1;
      chk("t6_rdy_rel", rdy8, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_rv_quiet", rv8, 0);
      end
      chk("t6_tot", tot8, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
